seg7_scan: RTL and testbench
============================

# seg7_scan

Multiplexed seven-segment display scanner that sits directly downstream of the clock divider. It samples the divider's slow square-wave output as a level in the system clock domain and advances one digit per rising edge of that wave. Each displayed digit is a hex nibble, with optional leading-zero blanking and per-digit decimal points. Display data is double-buffered and swapped only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- DIGITS, 8, number of digits scanned; legal range 1..8.
- I_CLK  input  1  system clock. The divider runs on this same clock.
- rst  input  1  reset; synchronous, active-high.
- scan_tick  input  1  divider output, sampled as a level; each 0→1 transition advances the scan by one digit.
- data  input  4*DIGITS  hex value to display; digit i = data[4i+3:4i]; digit 0 is the rightmost digit.
- dp  input  DIGITS  decimal point enables; dp[i] = 1 lights the point of digit i.
- blank_lz  input  1  leading-zero blanking enable.
- load  input  1  capture request for data/dp/blank_lz.
- o_an  output  DIGITS  digit anode enables; active-low, one-hot.
- o_seg  output  7  segments {g,f,e,d,c,b,a}; active-low.
- o_dp  output  1  decimal point; active-low.
- o_frame  output  1  one-cycle pulse at the start of each frame.

## Operation
- Edge detect:
  - tick_q is a register holding scan_tick from the previous cycle.
  - adv = scan_tick & ~tick_q.
  - A scan_tick held high produces exactly one adv.
- Digit index:
  - idx has width ceil(log2(DIGITS)), minimum 1 bit.
  - When adv is set, idx increments; when idx = DIGITS-1, it wraps to 0 instead (wrap).
  - When adv is clear, idx holds.
- Buffering:
  - pending register {data, dp, blank_lz} loads on any cycle with load = 1.
  - active register loads from pending on the wrap edge only.
  - load and wrap in the same cycle: pending takes the new inputs and active takes the old pending contents. The new value is displayed one frame later.
  - Repeated loads within a frame: only the last one is displayed.
- Blanking:
  - Digit i (i ≥ 1) is blanked when active.blank_lz = 1 and nibbles i..DIGITS-1 of active.data are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives o_seg = 7'h7F. Its anode and dp still follow normal rules.
- Decode for nibbles 0-F (active-low {g..a}): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Registered outputs, recomputed every cycle from the current idx and active register:
  - o_an = ~(1 << idx).
  - o_seg = decode or blank.
  - o_dp = ~active.dp[idx].

## Timing
- Reset (synchronous, highest priority; overrides load and adv in the same cycle):
  - idx = 0, tick_q = 0, pending = 0, active = 0.
  - o_an = all ones, o_seg = 7'h7F, o_dp = 1, o_frame = 0.
- First output cycle: on the first edge with rst = 0, outputs show digit 0 with o_an = ~1 (8'hFE at default) and o_seg = 7'h40.
- Latency:
  - scan_tick rising at edge N-1 is seen by tick_q-compare at edge N.
  - idx updates at edge N.
  - o_an/o_seg/o_dp reflect the new idx at edge N+1.
- o_frame is high for exactly the one cycle after the wrap edge. This is the same cycle in which outputs first show digit 0 of the new active contents.
- rst asserted mid-scan: all state returns to reset values at that edge, the scan restarts at digit 0, and pending content is lost.
- DIGITS = 1: every adv is a wrap, so active reloads and o_frame pulses on every adv.
- Outputs are glitch-free: every output is driven directly from a flop.

## Test plan
- Reset: hold rst for 3 cycles with random inputs, then release → during reset o_an = FF, o_seg = 7F, o_dp = 1, o_frame = 0; one cycle after release o_an = FE, o_seg = 40.
- Scan sweep: load data = 32'h12345678, dp = 8'h01, blank_lz = 0, then drive scan_tick with period 20 cycles → after the first wrap, per digit (o_an, o_seg) = (FE,00 with o_dp = 0), (FD,78), (FB,02), (F7,12), (EF,19), (DF,30), (BF,24), (7F,79); o_frame pulses once per 8 adv.
- Held tick: scan_tick held high for 50 cycles → idx advances exactly once.
- Blanking: load data = 32'h00000A00 with blank_lz = 1 → digits 7..3 show o_seg = 7F; digit 2 shows 08; digits 1 and 0 show 40. Repeat with blank_lz = 0 → digits 7..3 show 40.
- Tearing: load 32'h11111111, let it reach display, then load 32'h22222222 while idx = 3 → digits 4..7 of that frame still show 79; the next frame shows 24 on all digits.
- Coincident load/wrap: assert load with data = 32'hFFFFFFFF in the same cycle as the 7→0 adv → the following frame shows the previous pending value and the frame after that shows 0E on all digits. Assert rst at idx = 5 → the next output is o_an = FE with active = 0.

Source files
------------

// File: rtl/seg7_scan.sv
// =============================================================================
// Module      : seg7_scan
// Description : Multiplexed hex seven-segment scanner with double-buffered
//               display data, leading-zero blanking and per-digit points.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module seg7_scan #(
    parameter int DIGITS = 8
) (
    input  logic                  I_CLK,
    input  logic                  rst,
    input  logic                  scan_tick,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [DIGITS-1:0]     o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_frame
);

    localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic                  tick_q;
    logic [IW-1:0]         idx_q,       idx_d;
    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q,   pend_dp_d;
    logic                  pend_blz_q,  pend_blz_d;
    logic [4*DIGITS-1:0]   act_data_q,  act_data_d;
    logic [DIGITS-1:0]     act_dp_q,    act_dp_d;
    logic                  act_blz_q,   act_blz_d;
    logic                  wrap_q;
    logic [DIGITS-1:0]     an_q,        an_d;
    logic [6:0]            seg_q,       seg_d;
    logic                  dp_q,        dp_d;
    logic                  frame_q;

    logic                  adv;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  blank;
    logic [DIGITS-1:0]     sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'h40;
            4'h1:    seg_decode = 7'h79;
            4'h2:    seg_decode = 7'h24;
            4'h3:    seg_decode = 7'h30;
            4'h4:    seg_decode = 7'h19;
            4'h5:    seg_decode = 7'h12;
            4'h6:    seg_decode = 7'h02;
            4'h7:    seg_decode = 7'h78;
            4'h8:    seg_decode = 7'h00;
            4'h9:    seg_decode = 7'h10;
            4'hA:    seg_decode = 7'h08;
            4'hB:    seg_decode = 7'h03;
            4'hC:    seg_decode = 7'h46;
            4'hD:    seg_decode = 7'h21;
            4'hE:    seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        adv  = scan_tick & ~tick_q;
        wrap = adv & (idx_q == LAST_IDX);

        idx_d = idx_q;
        if (adv) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_blz_d  = pend_blz_q;
        if (load) begin
            pend_data_d = data;
            pend_dp_d   = dp;
            pend_blz_d  = blank_lz;
        end

        // Active copy takes the pre-load pending value, so a coincident load waits a frame.
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_blz_d  = act_blz_q;
        if (wrap) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_blz_d  = pend_blz_q;
        end

        // Digit i is a leading zero when every nibble from i upward is zero.
        nib   = act_data_q[{idx_q, 2'b00} +: 4];
        blank = act_blz_q && (idx_q != '0) && ((act_data_q >> {idx_q, 2'b00}) == '0);

        sel        = '0;
        sel[idx_q] = 1'b1;
        an_d       = ~sel;
        seg_d      = blank ? 7'h7F : seg_decode(nib);
        dp_d       = ~act_dp_q[idx_q];
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            tick_q      <= 1'b0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_blz_q  <= 1'b0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blz_q   <= 1'b0;
            wrap_q      <= 1'b0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            tick_q      <= scan_tick;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_blz_q  <= pend_blz_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blz_q   <= act_blz_d;
            wrap_q      <= wrap;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= wrap_q;
        end
    end

    assign o_an    = an_q;
    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_frame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// =============================================================================
// Module      : tb_seg7_scan
// Description : Directed self-checking bench for seg7_scan (DIGITS = 8).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_seg7_scan;

    logic        I_CLK = 1'b0;
    logic        rst = 1'b1;
    logic        scan_tick = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = 0;
    logic fr1;
    logic fr2;

    seg7_scan #(.DIGITS(8)) dut (
        .I_CLK    (I_CLK),
        .rst      (rst),
        .scan_tick(scan_tick),
        .data     (data),
        .dp       (dp),
        .blank_lz (blank_lz),
        .load     (load),
        .o_an     (o_an),
        .o_seg    (o_seg),
        .o_dp     (o_dp),
        .o_frame  (o_frame)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic b);
        data     = d;
        dp       = p;
        blank_lz = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // One 20-cycle scan_tick period; optional load coincident with the advance.
    task automatic adv(input bit ld, input logic [31:0] ld_data);
        scan_tick = 1'b1;
        if (ld) begin
            data = ld_data;
            load = 1'b1;
        end
        tick();
        load = 1'b0;
        tick();
        fr1 = o_frame;
        tick();
        fr2 = o_frame;
        repeat (7) tick();
        scan_tick = 1'b0;
        repeat (10) tick();
        cur = (cur + 1) % 8;
    endtask

    task automatic adv_chk(input string tag, input logic [6:0] seg_e, input logic dp_e,
                           input logic fr_e, input bit ld, input logic [31:0] ld_data);
        logic [7:0] an_e;
        adv(ld, ld_data);
        an_e = ~(8'h01 << cur);
        chk($sformatf("%s_an%0d", tag, cur), {24'h0, o_an}, {24'h0, an_e});
        chk($sformatf("%s_seg%0d", tag, cur), {25'h0, o_seg}, {25'h0, seg_e});
        chk($sformatf("%s_dp%0d", tag, cur), {31'h0, o_dp}, {31'h0, dp_e});
        chk($sformatf("%s_frame%0d", tag, cur), {31'h0, fr1}, {31'h0, fr_e});
        chk($sformatf("%s_frame_end%0d", tag, cur), {31'h0, fr2}, 32'h0);
    endtask

    // Entry with the scan on digit 7: checks digits 0..7 of the next frame.
    task automatic show_frame(input string tag, input logic [55:0] segs, input logic [7:0] dps);
        for (int i = 0; i < 8; i++) begin
            adv_chk(tag, segs[7*i +: 7], ~dps[i], (i == 0), 1'b0, 32'h0);
        end
    endtask

    task automatic advance_to(input int target);
        while (cur != target) adv(1'b0, 32'h0);
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            data      = $urandom;
            dp        = 8'($urandom);
            blank_lz  = 1'($urandom_range(0, 1));
            load      = 1'($urandom_range(0, 1));
            scan_tick = 1'($urandom_range(0, 1));
            chk("rst_an", {24'h0, o_an}, 32'h0000_00FF);
            chk("rst_seg", {25'h0, o_seg}, 32'h0000_007F);
            chk("rst_dp", {31'h0, o_dp}, 32'h1);
            chk("rst_frame", {31'h0, o_frame}, 32'h0);
        end
        tick();
        rst       = 1'b0;
        load      = 1'b0;
        scan_tick = 1'b0;
        data      = '0;
        dp        = '0;
        blank_lz  = 1'b0;
        tick();
        chk("first_an", {24'h0, o_an}, 32'h0000_00FE);
        chk("first_seg", {25'h0, o_seg}, 32'h0000_0040);
        chk("first_dp", {31'h0, o_dp}, 32'h1);
        cur = 0;

        // Scan sweep
        do_load(32'h1234_5678, 8'h01, 1'b0);
        advance_to(7);
        show_frame("sweep", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'h01);

        // Held tick: one advance only (7 -> 0 wrap)
        scan_tick = 1'b1;
        repeat (50) tick();
        scan_tick = 1'b0;
        repeat (3) tick();
        cur = 0;
        chk("held_an", {24'h0, o_an}, 32'h0000_00FE);
        chk("held_seg", {25'h0, o_seg}, 32'h0000_0000);
        chk("held_frame_idle", {31'h0, o_frame}, 32'h0);

        // Leading-zero blanking on, then off
        do_load(32'h0000_0A00, 8'h00, 1'b1);
        advance_to(7);
        show_frame("blank_on", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40}, 8'h00);
        do_load(32'h0000_0A00, 8'h00, 1'b0);
        show_frame("blank_off", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40}, 8'h00);

        // Tearing: mid-frame load must not alter the frame in progress
        do_load(32'h1111_1111, 8'h00, 1'b0);
        show_frame("tear_a", {8{7'h79}}, 8'h00);
        for (int i = 0; i < 4; i++) adv_chk("tear_lo", 7'h79, 1'b1, (i == 0), 1'b0, 32'h0);
        do_load(32'h2222_2222, 8'h00, 1'b0);
        for (int i = 4; i < 8; i++) adv_chk("tear_hi", 7'h79, 1'b1, 1'b0, 1'b0, 32'h0);
        show_frame("tear_b", {8{7'h24}}, 8'h00);

        // Coincident load and wrap
        do_load(32'h3333_3333, 8'h00, 1'b0);
        adv_chk("coin", 7'h30, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        for (int i = 1; i < 8; i++) adv_chk("coin", 7'h30, 1'b1, 1'b0, 1'b0, 32'h0);
        show_frame("coin_next", {8{7'h0E}}, 8'h00);

        // Reset mid-scan at digit 5
        advance_to(5);
        rst = 1'b1;
        tick();
        chk("midrst_an", {24'h0, o_an}, 32'h0000_00FF);
        chk("midrst_seg", {25'h0, o_seg}, 32'h0000_007F);
        rst = 1'b0;
        tick();
        cur = 0;
        chk("postrst_an", {24'h0, o_an}, 32'h0000_00FE);
        chk("postrst_seg", {25'h0, o_seg}, 32'h0000_0040);
        chk("postrst_dp", {31'h0, o_dp}, 32'h1);
        advance_to(7);
        show_frame("postrst", {8{7'h40}}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
